// File: rtl/zed_modeline_ctrl.sv
// zed_modeline_ctrl: CPU-writable modeline table, shadow load and commit.
// Button selection is built only when ZED_MODECTL_BUTTON_EN is defined.
module zed_modeline_ctrl #(
   parameter int NUM_MODES       = 4,
   parameter int TW              = 12,
   parameter int DEBOUNCE_CYCLES = 65536
) (
   input  logic          cpu_clk,
   input  logic          act_reset,
   input  logic          button,
   input  logic [7:0]    cpu_addr,
   input  logic [7:0]    cpu_wdata,
   input  logic          cpu_wr,
   input  logic          cpu_rd,
   output logic [7:0]    cpu_rdata,
   output logic [TW-1:0] hdisp,
   output logic [TW-1:0] hstart,
   output logic [TW-1:0] hend,
   output logic [TW-1:0] htotal,
   output logic [TW-1:0] vdisp,
   output logic [TW-1:0] vstart,
   output logic [TW-1:0] vend,
   output logic [TW-1:0] vtotal,
   output logic          hsi,
   output logic          vsi,
   output logic [3:0]    mode_idx,
   output logic          commit_toggle,
   output logic          busy
);

   localparam int MW = $clog2(NUM_MODES);
   localparam int NF = NUM_MODES * 8;
   localparam logic [8:0] TBL_BYTES = 9'(NUM_MODES * 16);
   localparam logic [7:0] A_MODE   = 8'hF0;
   localparam logic [7:0] A_STAT   = 8'hF1;
   localparam logic [7:0] A_COMMIT = 8'hF2;

   // hsi/vsi live in bit 15 of htotal/vtotal
   localparam logic [15:0] DFLT [32] = '{
      16'd1280, 16'd1390, 16'd1430, 16'd1650,
      16'd720,  16'd725,  16'd730,  16'd750,
      16'd1280, 16'd1328, 16'd1440, 16'd1688,
      16'd1024, 16'd1025, 16'd1028, 16'd1066,
      16'd720,  16'd736,  16'd798,  16'h8000 | 16'd858,
      16'd480,  16'd489,  16'd495,  16'h8000 | 16'd525,
      16'd800,  16'd840,  16'd968,  16'd1056,
      16'd600,  16'd601,  16'd605,  16'd628
   };

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      COMMIT
   } state_t;

   function automatic logic [15:0] fmask(input logic [2:0] f);
      logic [15:0] m;
      m = 16'((17'd1 << TW) - 17'd1);
      if (f == 3'd3 || f == 3'd7) m[15] = 1'b1;
      return m;
   endfunction

   function automatic logic [15:0] dflt(input logic [1:0] m,
                                        input logic [2:0] f);
      return DFLT[{m, f}] & fmask(f);
   endfunction

   state_t        state, state_n;
   logic [2:0]    fcnt, fcnt_n;
   logic [MW-1:0] tgt, tgt_n;
   logic [MW-1:0] pend_mode, pend_n;
   logic          pend_v, pend_v_n;
   logic [MW-1:0] mode_r;
   logic          cap, commit;
   logic [15:0]   tbl [NF];
   logic [15:0]   shadow [8];

   logic          is_ctrl, in_tbl, tbl_wr;
   logic [MW+2:0] tbl_idx;
   logic [15:0]   tbl_old, tbl_wdat;
   logic [7:0]    rd_mux;
   logic          trig_cpu, trig, btn_evt;
   logic [MW-1:0] cpu_req, btn_req, req;

   assign is_ctrl = (cpu_addr == A_MODE) || (cpu_addr == A_STAT) ||
                    (cpu_addr == A_COMMIT);
   assign in_tbl  = ({1'b0, cpu_addr} < TBL_BYTES) && !is_ctrl;
   assign tbl_idx = cpu_addr[MW+3:1];
   assign tbl_old = tbl[tbl_idx];
   assign tbl_wr  = cpu_wr && in_tbl;
   assign tbl_wdat = (cpu_addr[0] ? {cpu_wdata, tbl_old[7:0]}
                                  : {tbl_old[15:8], cpu_wdata})
                     & fmask(cpu_addr[3:1]);

   always_comb begin
      rd_mux = 8'h00;
      if (cpu_addr == A_STAT)
         rd_mux = {mode_idx, 2'b00, pend_v, busy};
      else if (in_tbl)
         rd_mux = cpu_addr[0] ? tbl_old[15:8] : tbl_old[7:0];
   end

`ifdef ZED_MODECTL_BUTTON_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [1:0]    btn_sync;
   logic [CW-1:0] db_cnt;
   logic          db_lvl, db_lvl_q;

   always_ff @(posedge cpu_clk or posedge act_reset) begin
      if (act_reset) begin
         btn_sync <= 2'b00;
         db_cnt   <= '0;
         db_lvl   <= 1'b0;
         db_lvl_q <= 1'b0;
      end else begin
         btn_sync <= {btn_sync[0], button};
         db_lvl_q <= db_lvl;
         if (btn_sync[1] == db_lvl) begin
            db_cnt <= '0;
         end else if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            db_lvl <= btn_sync[1];
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + CW'(1);
         end
      end
   end

   assign btn_evt = db_lvl & ~db_lvl_q;
`else
   logic unused_btn;
   assign unused_btn = button ^ (DEBOUNCE_CYCLES == 0);
   assign btn_evt    = 1'b0;
`endif

   assign trig_cpu = cpu_wr &&
                     (cpu_addr == A_MODE || cpu_addr == A_COMMIT);
   assign cpu_req  = (cpu_addr == A_MODE) ? cpu_wdata[MW-1:0] : mode_r;
   // A queued request is the base for a button step
   assign btn_req  = (pend_v ? pend_mode : mode_r) + MW'(1);
   assign trig     = trig_cpu || btn_evt;
   assign req      = trig_cpu ? cpu_req : btn_req;

   always_comb begin
      state_n  = state;
      fcnt_n   = fcnt;
      tgt_n    = tgt;
      pend_v_n = pend_v;
      pend_n   = pend_mode;
      cap      = 1'b0;
      commit   = 1'b0;
      unique case (state)
         IDLE: begin
            if (trig) begin
               state_n = LOAD;
               fcnt_n  = 3'd0;
               tgt_n   = req;
            end
         end
         LOAD: begin
            cap    = 1'b1;
            fcnt_n = fcnt + 3'd1;
            if (fcnt == 3'd7) state_n = COMMIT;
            if (trig) begin
               pend_v_n = 1'b1;
               pend_n   = req;
            end
         end
         COMMIT: begin
            commit = 1'b1;
            fcnt_n = 3'd0;
            if (trig) begin
               state_n  = LOAD;
               tgt_n    = req;
               pend_v_n = 1'b0;
            end else if (pend_v) begin
               state_n  = LOAD;
               tgt_n    = pend_mode;
               pend_v_n = 1'b0;
            end else begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge cpu_clk or posedge act_reset) begin
      if (act_reset) begin
         for (int i = 0; i < NF; i++)
            tbl[i] <= dflt(2'(i / 8), 3'(i % 8));
      end else if (tbl_wr) begin
         tbl[tbl_idx] <= tbl_wdat;
      end
   end

   always_ff @(posedge cpu_clk or posedge act_reset) begin
      if (act_reset) begin
         state         <= IDLE;
         fcnt          <= 3'd0;
         tgt           <= '0;
         pend_v        <= 1'b0;
         pend_mode     <= '0;
         mode_r        <= '0;
         commit_toggle <= 1'b0;
         cpu_rdata     <= 8'h00;
         for (int i = 0; i < 8; i++) shadow[i] <= 16'h0000;
         hdisp  <= TW'(dflt(2'd0, 3'd0));
         hstart <= TW'(dflt(2'd0, 3'd1));
         hend   <= TW'(dflt(2'd0, 3'd2));
         htotal <= TW'(dflt(2'd0, 3'd3));
         vdisp  <= TW'(dflt(2'd0, 3'd4));
         vstart <= TW'(dflt(2'd0, 3'd5));
         vend   <= TW'(dflt(2'd0, 3'd6));
         vtotal <= TW'(dflt(2'd0, 3'd7));
         hsi    <= 1'b0;
         vsi    <= 1'b0;
      end else begin
         state     <= state_n;
         fcnt      <= fcnt_n;
         tgt       <= tgt_n;
         pend_v    <= pend_v_n;
         pend_mode <= pend_n;
         if (cpu_rd) cpu_rdata <= rd_mux;
         if (cap) shadow[fcnt] <= tbl[{tgt, fcnt}];
         if (commit) begin
            hdisp  <= TW'(shadow[0]);
            hstart <= TW'(shadow[1]);
            hend   <= TW'(shadow[2]);
            htotal <= TW'(shadow[3]);
            vdisp  <= TW'(shadow[4]);
            vstart <= TW'(shadow[5]);
            vend   <= TW'(shadow[6]);
            vtotal <= TW'(shadow[7]);
            hsi    <= shadow[3][15];
            vsi    <= shadow[7][15];
            mode_r <= tgt;
            commit_toggle <= ~commit_toggle;
         end
      end
   end

   assign busy     = (state != IDLE);
   assign mode_idx = 4'(mode_r);

endmodule
